// File: rtl/wb_modport.sv
// Wishbone B4 pipelined register slice: two-entry skid buffer on the request path, registered response path.
// Define WB_MODPORT_ERR_EN to forward m_err_i as s_err_o; otherwise errors are folded into acks.
module wb_modport #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int GRANULARITY     = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [ADDR_WIDTH-1:0]               s_adr_i,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                s_we_i,
    input  logic [DATA_WIDTH/GRANULARITY-1:0]   s_sel_i,
    input  logic                                s_stb_i,
    input  logic                                s_cyc_i,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic                                s_ack_o,
    output logic                                s_err_o,
    output logic                                s_stall_o,
    output logic [ADDR_WIDTH-1:0]               m_adr_o,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic                                m_we_o,
    output logic [DATA_WIDTH/GRANULARITY-1:0]   m_sel_o,
    output logic                                m_stb_o,
    output logic                                m_cyc_o,
    input  logic [DATA_WIDTH-1:0]               m_dat_i,
    input  logic                                m_ack_i,
    input  logic                                m_err_i,
    input  logic                                m_stall_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULARITY;
    localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);

    if (GRANULARITY != 8 && GRANULARITY != 16 && GRANULARITY != 32) begin : g_bad_granularity
        $fatal(1, "wb_modport: GRANULARITY must be 8, 16 or 32");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_outstanding
        $fatal(1, "wb_modport: MAX_OUTSTANDING must be in 1..15");
    end

    logic                  out_valid;
    logic                  skid_valid;
    logic [ADDR_WIDTH-1:0] skid_adr;
    logic [DATA_WIDTH-1:0] skid_dat;
    logic                  skid_we;
    logic [SEL_WIDTH-1:0]  skid_sel;
    logic [3:0]            cnt;

    logic accept;
    logic issue;
    logic out_free;
    logic resp_valid;
    logic ack_in;
    logic err_in;

    assign m_stb_o    = out_valid && (cnt != CNT_MAX);
    assign issue      = m_stb_o && !m_stall_i;
    assign accept     = s_cyc_i && s_stb_i && !skid_valid;
    assign out_free   = !out_valid || issue;
    assign s_stall_o  = skid_valid;
    assign resp_valid = (m_ack_i || m_err_i) && (cnt != 4'd0);

`ifdef WB_MODPORT_ERR_EN
    assign ack_in = m_ack_i && !m_err_i;
    assign err_in = m_err_i;
`else
    assign ack_in = m_ack_i || m_err_i;
    assign err_in = 1'b0;
`endif

    // The skid entry always drains into the output register before a new request can.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            m_we_o     <= 1'b0;
            m_sel_o    <= '0;
            skid_adr   <= '0;
            skid_dat   <= '0;
            skid_we    <= 1'b0;
            skid_sel   <= '0;
        end else if (!s_cyc_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                m_adr_o    <= skid_adr;
                m_dat_o    <= skid_dat;
                m_we_o     <= skid_we;
                m_sel_o    <= skid_sel;
            end else if (accept) begin
                out_valid <= 1'b1;
                m_adr_o   <= s_adr_i;
                m_dat_o   <= s_dat_i;
                m_we_o    <= s_we_i;
                m_sel_o   <= s_sel_i;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_adr   <= s_adr_i;
            skid_dat   <= s_dat_i;
            skid_we    <= s_we_i;
            skid_sel   <= s_sel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= 4'd0;
        end else if (!s_cyc_i) begin
            cnt <= 4'd0;
        end else if (issue && !resp_valid) begin
            cnt <= cnt + 4'd1;
        end else if (!issue && resp_valid) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Responses only pass while the upstream cycle is live and something is actually outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cyc_o <= 1'b0;
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_dat_o <= '0;
        end else begin
            m_cyc_o <= s_cyc_i;
            s_ack_o <= s_cyc_i && (cnt != 4'd0) && ack_in;
            s_err_o <= s_cyc_i && (cnt != 4'd0) && err_in;
            if (s_cyc_i && (cnt != 4'd0) && ack_in) begin
                s_dat_o <= m_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_modport.sv
// Self-checking bench for wb_modport: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level queue model.
module tb_wb_modport;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int SW   = 4;
    localparam int MAXO = 2;
`ifdef WB_MODPORT_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [AW-1:0] s_adr_i = '0;
    logic [DW-1:0] s_dat_i = '0;
    logic          s_we_i = 1'b0;
    logic [SW-1:0] s_sel_i = '0;
    logic          s_stb_i = 1'b0;
    logic          s_cyc_i = 1'b0;
    logic [DW-1:0] s_dat_o;
    logic          s_ack_o;
    logic          s_err_o;
    logic          s_stall_o;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic          m_we_o;
    logic [SW-1:0] m_sel_o;
    logic          m_stb_o;
    logic          m_cyc_o;
    logic [DW-1:0] m_dat_i = '0;
    logic          m_ack_i = 1'b0;
    logic          m_err_i = 1'b0;
    logic          m_stall_i = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;

    wb_modport #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRANULARITY(8), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_stall_o(s_stall_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_stall_i(m_stall_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        stall;
        logic        ack;
        logic [31:0] mdat;
        logic        e_stb;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic        e_we;
        logic [3:0]  e_sel;
        logic        e_stall;
        logic        e_ack;
        logic [31:0] e_sdat;
        logic        e_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } req_t;

    vec_t vecs[14];
    req_t req_q[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                                 input logic stall, input logic ack, input logic err,
                                 input logic [31:0] mdat);
        s_cyc_i   = cyc;
        s_stb_i   = stb;
        s_we_i    = we;
        s_adr_i   = adr;
        s_dat_i   = dat;
        s_sel_i   = sel;
        m_stall_i = stall;
        m_ack_i   = ack;
        m_err_i   = err;
        m_dat_i   = mdat;
    endtask

    task automatic tick;
        @(negedge clk_i);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_s_dat"}, 64'(s_dat_o), 64'h0);
        checkOutput({tag, "_m_adr"}, 64'(m_adr_o), 64'h0);
        checkOutput({tag, "_m_dat"}, 64'(m_dat_o), 64'h0);
        checkOutput({tag, "_ctrl"},
                    64'({s_ack_o, s_err_o, s_stall_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o}), 64'h0);
    endtask

    // Asynchronous reset in the middle of a clock phase, then release at the next falling edge.
    task automatic asyncReset(input string tag);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        checkAllZero(tag);
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic O, Z;
        logic exp_ack, exp_err, exp_cyc, exp_stb;
        logic [31:0] exp_dat;
        int ost;
        O = 1'b1;
        Z = 1'b0;

        vecs[0]  = '{O,O,O,32'h10,32'hDEADBEEF,4'hF,Z,Z,32'h0,  O,32'h10,32'hDEADBEEF,O,4'hF,  Z,Z,32'h0,O};
        vecs[1]  = '{O,Z,Z,32'h0,32'h0,4'h0,Z,Z,32'h0,          Z,32'h0,32'h0,Z,4'h0,          Z,Z,32'h0,O};
        vecs[2]  = '{O,Z,Z,32'h0,32'h0,4'h0,Z,O,32'hCAFEF00D,   Z,32'h0,32'h0,Z,4'h0,          Z,O,32'hCAFEF00D,O};
        vecs[3]  = '{O,Z,Z,32'h0,32'h0,4'h0,Z,Z,32'h0,          Z,32'h0,32'h0,Z,4'h0,          Z,Z,32'h0,O};
        vecs[4]  = '{O,O,Z,32'h100,32'h0,4'hF,O,Z,32'h0,        O,32'h100,32'h0,Z,4'hF,        Z,Z,32'h0,O};
        vecs[5]  = '{O,O,Z,32'h104,32'h0,4'hF,O,Z,32'h0,        O,32'h100,32'h0,Z,4'hF,        O,Z,32'h0,O};
        vecs[6]  = '{O,O,Z,32'h108,32'h0,4'hF,O,Z,32'h0,        O,32'h100,32'h0,Z,4'hF,        O,Z,32'h0,O};
        vecs[7]  = '{O,O,Z,32'h108,32'h0,4'hF,Z,Z,32'h0,        O,32'h104,32'h0,Z,4'hF,        Z,Z,32'h0,O};
        vecs[8]  = '{O,O,Z,32'h108,32'h0,4'hF,Z,Z,32'h0,        Z,32'h0,32'h0,Z,4'h0,          Z,Z,32'h0,O};
        vecs[9]  = '{O,O,Z,32'h10C,32'h0,4'hF,Z,O,32'h1,        O,32'h108,32'h0,Z,4'hF,        O,O,32'h1,O};
        vecs[10] = '{O,Z,Z,32'h0,32'h0,4'h0,Z,O,32'h2,          O,32'h10C,32'h0,Z,4'hF,        Z,O,32'h2,O};
        vecs[11] = '{O,Z,Z,32'h0,32'h0,4'h0,Z,O,32'h3,          Z,32'h0,32'h0,Z,4'h0,          Z,O,32'h3,O};
        vecs[12] = '{O,Z,Z,32'h0,32'h0,4'h0,Z,O,32'h4,          Z,32'h0,32'h0,Z,4'h0,          Z,O,32'h4,O};
        vecs[13] = '{O,Z,Z,32'h0,32'h0,4'h0,Z,Z,32'h0,          Z,32'h0,32'h0,Z,4'h0,          Z,Z,32'h0,O};

        #1 rst_i = 1'b1;
        #2 checkAllZero("reset");
        tick();
        tick();
        rst_i = 1'b0;

        // Directed table: single write, then four reads through a three-cycle downstream stall.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                          vecs[i].stall, vecs[i].ack, 1'b0, vecs[i].mdat);
            tick();
            checkOutput($sformatf("vec%0d_m_stb", i), 64'(m_stb_o), 64'(vecs[i].e_stb));
            if (vecs[i].e_stb) begin
                checkOutput($sformatf("vec%0d_m_adr", i), 64'(m_adr_o), 64'(vecs[i].e_adr));
                checkOutput($sformatf("vec%0d_m_dat", i), 64'(m_dat_o), 64'(vecs[i].e_dat));
                checkOutput($sformatf("vec%0d_m_we", i), 64'(m_we_o), 64'(vecs[i].e_we));
                checkOutput($sformatf("vec%0d_m_sel", i), 64'(m_sel_o), 64'(vecs[i].e_sel));
            end
            checkOutput($sformatf("vec%0d_s_stall", i), 64'(s_stall_o), 64'(vecs[i].e_stall));
            checkOutput($sformatf("vec%0d_s_ack", i), 64'(s_ack_o), 64'(vecs[i].e_ack));
            if (vecs[i].e_ack) begin
                checkOutput($sformatf("vec%0d_s_dat", i), 64'(s_dat_o), 64'(vecs[i].e_sdat));
            end
            checkOutput($sformatf("vec%0d_s_err", i), 64'(s_err_o), 64'h0);
            checkOutput($sformatf("vec%0d_m_cyc", i), 64'(m_cyc_o), 64'(vecs[i].e_cyc));
        end

        // Abort with one request outstanding and two buffered; late acks must vanish.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("abort_pre_stb", 64'(m_stb_o), 64'h1);
        checkOutput("abort_pre_adr", 64'(m_adr_o), 64'h304);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h308, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("abort_full_stall", 64'(s_stall_o), 64'h1);
        checkOutput("abort_full_stb", 64'(m_stb_o), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("abort_m_stb", 64'(m_stb_o), 64'h0);
        checkOutput("abort_m_cyc", 64'(m_cyc_o), 64'h0);
        checkOutput("abort_s_stall", 64'(s_stall_o), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h55);
        tick();
        checkOutput("abort_late_ack", 64'(s_ack_o), 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h66);
        tick();
        checkOutput("abort_late_ack_cyc", 64'(s_ack_o), 64'h0);
        checkOutput("abort_recycle_cyc", 64'(m_cyc_o), 64'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // Error response alone, then ack and err together.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hBAD0BAD0);
        tick();
        checkOutput("err_s_err", 64'(s_err_o), 64'(ERR_ON));
        checkOutput("err_s_ack", 64'(s_ack_o), 64'(!ERR_ON));
        checkOutput("err_s_dat", 64'(s_dat_o), ERR_ON ? 64'h4 : 64'hBAD0BAD0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("err_pulse_end", 64'({s_err_o, s_ack_o}), 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h12345678);
        tick();
        checkOutput("ackerr_s_err", 64'(s_err_o), 64'(ERR_ON));
        checkOutput("ackerr_s_ack", 64'(s_ack_o), 64'(!ERR_ON));
        checkOutput("ackerr_s_dat", 64'(s_dat_o), ERR_ON ? 64'h4 : 64'h12345678);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // Reset dropped into a live burst; a following ack must find nothing outstanding.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h404, 32'h5A5A5A5A, 4'hC, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("burst_m_adr", 64'(m_adr_o), 64'h404);
        checkOutput("burst_m_sel", 64'(m_sel_o), 64'hC);
        asyncReset("midreset");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h77);
        tick();
        checkOutput("midreset_cnt_clear", 64'(s_ack_o), 64'h0);
        checkOutput("midreset_m_stb", 64'(m_stb_o), 64'h0);

        // Random traffic against a queue model of the buffered requests and an outstanding count.
        req_q.delete();
        ost     = 0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = 32'h0;
        exp_cyc = 1'b1;
        for (int cyc_n = 0; cyc_n < 400; cyc_n++) begin
            logic r_cyc, r_stb, r_we, r_stall, r_ack, r_err, issue, accept, resp;
            logic [31:0] r_adr, r_dat, r_mdat;
            logic [3:0] r_sel;
            req_t nr;

            exp_stb = (req_q.size() > 0) && (ost < MAXO);
            checkOutput("rnd_s_ack", 64'(s_ack_o), 64'(exp_ack));
            checkOutput("rnd_s_err", 64'(s_err_o), 64'(exp_err));
            if (exp_ack) checkOutput("rnd_s_dat", 64'(s_dat_o), 64'(exp_dat));
            checkOutput("rnd_m_cyc", 64'(m_cyc_o), 64'(exp_cyc));
            checkOutput("rnd_s_stall", 64'(s_stall_o), 64'(req_q.size() == 2));
            checkOutput("rnd_m_stb", 64'(m_stb_o), 64'(exp_stb));
            if (exp_stb) begin
                checkOutput("rnd_m_adr", 64'(m_adr_o), 64'(req_q[0].adr));
                checkOutput("rnd_m_fields", 64'({m_dat_o, m_we_o, m_sel_o}),
                            64'({req_q[0].dat, req_q[0].we, req_q[0].sel}));
            end

            r_cyc   = ($urandom_range(0, 31) != 0);
            r_stb   = ($urandom_range(0, 2) != 0);
            r_we    = 1'($urandom_range(0, 1));
            r_adr   = $urandom;
            r_dat   = $urandom;
            r_sel   = 4'($urandom_range(0, 15));
            r_stall = ($urandom_range(0, 2) == 0);
            r_mdat  = $urandom;
            if (ost > 0) begin
                r_ack = 1'($urandom_range(0, 1));
                r_err = ($urandom_range(0, 7) == 0);
            end else begin
                r_ack = ($urandom_range(0, 15) == 0);
                r_err = 1'b0;
            end
            applyStimulus(r_cyc, r_stb, r_we, r_adr, r_dat, r_sel, r_stall, r_ack, r_err, r_mdat);

            issue  = exp_stb && !r_stall;
            accept = r_cyc && r_stb && (req_q.size() < 2);
            resp   = (r_ack || r_err) && (ost > 0);
            if (ERR_ON) begin
                exp_ack = r_cyc && (ost > 0) && r_ack && !r_err;
                exp_err = r_cyc && (ost > 0) && r_err;
            end else begin
                exp_ack = r_cyc && (ost > 0) && (r_ack || r_err);
                exp_err = 1'b0;
            end
            if (exp_ack) exp_dat = r_mdat;
            exp_cyc = r_cyc;
            if (!r_cyc) begin
                req_q.delete();
                ost = 0;
            end else begin
                if (issue) void'(req_q.pop_front());
                if (accept) begin
                    nr.adr = r_adr;
                    nr.dat = r_dat;
                    nr.we  = r_we;
                    nr.sel = r_sel;
                    req_q.push_back(nr);
                end
                ost = ost + (issue ? 1 : 0) - (resp ? 1 : 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/wb_modport.md
# wb_modport

Single-clock Wishbone B4 pipelined register slice with a slave port facing an upstream master and a master port facing a downstream slave. It breaks combinational paths on both request and response channels using a two-entry skid buffer and a registered response stage. It sits between an interconnect and a peripheral, or between two interconnect levels, for timing closure.

## Interface

- `DATA_WIDTH`, default 32: data bus width.
- `ADDR_WIDTH`, default 32: address width.
- `GRANULARITY`, default 8: select granularity. Allowed values are 8, 16 and 32; any other value is a fatal elaboration error.
- `MAX_OUTSTANDING`, default 4: maximum number of downstream requests issued but not yet answered (1..15).

Ports:

- `clk_i` in 1: clock. All logic runs on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `s_adr_i` in ADDR_WIDTH, `s_dat_i` in DATA_WIDTH, `s_we_i` in 1, `s_sel_i` in DATA_WIDTH/GRANULARITY, `s_stb_i` in 1, `s_cyc_i` in 1: upstream request.
- `s_dat_o` out DATA_WIDTH, `s_ack_o` out 1, `s_err_o` out 1, `s_stall_o` out 1: upstream response and stall.
- `m_adr_o` out ADDR_WIDTH, `m_dat_o` out DATA_WIDTH, `m_we_o` out 1, `m_sel_o` out DATA_WIDTH/GRANULARITY, `m_stb_o` out 1, `m_cyc_o` out 1: downstream request.
- `m_dat_i` in DATA_WIDTH, `m_ack_i` in 1, `m_err_i` in 1, `m_stall_i` in 1: downstream response and stall.

## Operation

- **Request accept.** A request is accepted when `s_cyc_i & s_stb_i & !s_stall_o`. It is loaded into the output register if that register is empty or draining this cycle; otherwise it goes into the skid register.
- **Issue.** The output register drives `m_adr_o`, `m_dat_o`, `m_we_o`, `m_sel_o` and `m_stb_o`.
  - A request is issued when `m_stb_o & !m_stall_i`.
  - `m_stb_o` is held low while `cnt == MAX_OUTSTANDING`; the request stays in the register.
- **Stall.** `s_stall_o` is registered and equals "skid register valid".
- **Outstanding counter.** `cnt` increments on issue and decrements on `m_ack_i | m_err_i`.
  - Simultaneous issue and response leaves `cnt` unchanged.
  - A response arriving while `cnt == 0` is ignored.
- **Cycle.** `m_cyc_o` is registered. It is 1 the cycle after `s_cyc_i` is high, and stays 1 while any buffer entry is valid or `cnt != 0`.
- **Response.**
  - `s_ack_o` and `s_err_o` are registered copies of `m_ack_i` and `m_err_i`, each gated by `s_cyc_i` and `cnt != 0`.
  - `s_dat_o` captures `m_dat_i` on ack and holds otherwise.
  - If `m_ack_i` and `m_err_i` arrive together, err wins.
- **Abort.** `s_cyc_i` low for one cycle:
  - flushes both buffer entries;
  - clears `cnt` and `s_stall_o`;
  - drives `m_stb_o` and `m_cyc_o` to 0 on the next edge.
  - Responses arriving afterwards are discarded.
- **Ordering.** Requests are issued in acceptance order and responses are returned in order. No reordering.

## Timing

- **Reset.** All outputs are 0: `s_dat_o`, `s_ack_o`, `s_err_o`, `s_stall_o`, `m_adr_o`, `m_dat_o`, `m_we_o`, `m_sel_o`, `m_stb_o`, `m_cyc_o`. `cnt` is 0 and both buffer entries are invalid. Reset mid-transaction drops everything immediately.
- **Request latency.** Request accepted at edge N appears on `m_stb_o` after edge N, with no downstream stall.
- **Response latency.** `m_ack_i` sampled at edge N produces `s_ack_o` high after edge N for exactly one cycle.
- **Throughput.** One request per cycle with `m_stall_i` low.
- **Stall propagation.** `m_stall_i` rising causes at most one extra request to be absorbed into the skid register. `s_stall_o` rises on the following edge.
- **Stall release.** When `m_stall_i` falls, the skid entry moves to the output register. `s_stall_o` falls on the same edge.

## Configuration

- **`WB_MODPORT_ERR_EN` defined:** error path as described; `m_err_i` produces `s_err_o`.
- **`WB_MODPORT_ERR_EN` undefined:**
  - `s_err_o` is constant 0.
  - `m_err_i` is treated as an ack: it produces `s_ack_o` and decrements `cnt`, and `s_dat_o` captures `m_dat_i`.

## Test plan

- **Reset.** Assert `rst_i` mid-burst, asynchronously to the clock -> all outputs 0 immediately, `cnt = 0`.
- **Single write.** Write `adr=0x10`, `dat=0xDEADBEEF`, `sel=0xF`, no stall -> `m_stb_o` one cycle later with identical fields. Slave acks the next cycle -> `s_ack_o` one cycle after that.
- **Back-to-back reads with stall.** Four back-to-back reads with `m_stall_i` high for 3 cycles -> `s_stall_o` high after one request is absorbed. Order is preserved; four `s_ack_o` pulses return data 0x1, 0x2, 0x3, 0x4.
- **Outstanding limit.** With `MAX_OUTSTANDING=2`, issue 3 reads while the downstream withholds ack -> only 2 issued, third held with `m_stb_o` low until the first ack.
- **Abort.** Drop `s_cyc_i` with 2 requests buffered -> `m_cyc_o` and `m_stb_o` are 0 next cycle; a late `m_ack_i` produces no `s_ack_o`.
- **Error.** Downstream drives `m_err_i` -> `s_err_o` pulse with `WB_MODPORT_ERR_EN` defined; `s_ack_o` pulse and `s_err_o = 0` without it.
